// File: rtl/complete_collector_if.sv
// Completion message type and en/msg/reject channel for complete_collector.
// master drives en/msg and samples reject; slave samples en/msg and drives reject.
package complete_collector_pkg;
  typedef struct packed {
    logic [7:0]  commit_id;
    logic [1:0]  kind;
    logic [31:0] content;
  } complete_info_t;
endpackage

interface complete_collector_if;
  import complete_collector_pkg::*;
  logic           en;
  complete_info_t msg;
  logic           reject;
  modport master (output en, output msg, input reject);
  modport slave  (input en, input msg, output reject);
endinterface

// File: rtl/complete_collector.sv
// Merges N_SRC completion streams through per-source FIFOs into one registered output, round-robin.
// Optional feature: define COMPLETE_BYPASS_EN for a 1-cycle path when every FIFO is empty.
module complete_collector
  import complete_collector_pkg::*;
#(
  parameter int N_SRC      = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  flash,
  complete_collector_if.slave   src [N_SRC-1:0],
  complete_collector_if.master  complete_info,
  output logic [N_SRC*4-1:0]    occupancy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(N_SRC);

  logic [N_SRC-1:0] src_en_s;
  logic [N_SRC-1:0] reject_s;
  logic [N_SRC-1:0] accept_s;
  logic [N_SRC-1:0] nonempty_s;
  logic [N_SRC-1:0] push_s;
  logic [N_SRC-1:0] pop_s;
  complete_info_t   src_msg_s [N_SRC];
  complete_info_t   head_s    [N_SRC];

  logic [SW-1:0]    rr_ptr_r;
  logic             out_valid_r;
  complete_info_t   out_msg_r;

  logic             can_load_s;
  logic             grant_valid_s;
  logic [SW-1:0]    grant_idx_s;
  logic             bypass_valid_s;
  logic [SW-1:0]    bypass_idx_s;

  function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    return SW'(s % N_SRC);
  endfunction

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    assign src_en_s[i]  = src[i].en;
    assign src_msg_s[i] = src[i].msg;
    assign src[i].reject = reject_s[i];
  end

  assign accept_s   = src_en_s & ~reject_s;
  assign can_load_s = !out_valid_r || !complete_info.reject;

  // Round-robin pick: first non-empty FIFO strictly after the last grant.
  always_comb begin
    logic    hit;
    logic [SW-1:0] idx;
    grant_valid_s = 1'b0;
    grant_idx_s   = '0;
    for (int off = 1; off <= N_SRC; off++) begin
      idx           = wrap_add(rr_ptr_r, off);
      hit           = !grant_valid_s && nonempty_s[idx];
      grant_idx_s   = hit ? idx : grant_idx_s;
      grant_valid_s = grant_valid_s | hit;
    end
  end

`ifdef COMPLETE_BYPASS_EN
  // Bypass pick: same rotation over live accepts, only when nothing is queued anywhere.
  always_comb begin
    logic    hit;
    logic    found;
    logic [SW-1:0] idx;
    found        = 1'b0;
    bypass_idx_s = '0;
    for (int off = 1; off <= N_SRC; off++) begin
      idx          = wrap_add(rr_ptr_r, off);
      hit          = !found && accept_s[idx];
      bypass_idx_s = hit ? idx : bypass_idx_s;
      found        = found | hit;
    end
    bypass_valid_s = found && can_load_s && (nonempty_s == '0);
  end
`else
  assign bypass_valid_s = 1'b0;
  assign bypass_idx_s   = '0;
`endif

  // A bypassed accept skips its FIFO; a pop happens only when the output can take it.
  always_comb begin
    push_s = '0;
    pop_s  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      push_s[i] = accept_s[i] && !(bypass_valid_s && (bypass_idx_s == SW'(i)));
      pop_s[i]  = grant_valid_s && can_load_s && (grant_idx_s == SW'(i));
    end
  end

  for (genvar i = 0; i < N_SRC; i++) begin : g_fifo
    complete_info_t mem_r [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_r;
    logic [PW-1:0]  rd_ptr_r;
    logic [3:0]     count_r;

    assign reject_s[i]          = (count_r == 4'(FIFO_DEPTH));
    assign nonempty_s[i]        = (count_r != 4'd0);
    assign head_s[i]            = mem_r[rd_ptr_r];
    assign occupancy[4*i +: 4]  = count_r;

    // Pointer and count bookkeeping; flash drops contents and any same-cycle push.
    always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
        count_r  <= 4'd0;
      end else if (flash) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
        count_r  <= 4'd0;
      end else begin
        if (push_s[i]) begin
          wr_ptr_r <= wr_ptr_r + PW'(1);
        end
        if (pop_s[i]) begin
          rd_ptr_r <= rd_ptr_r + PW'(1);
        end
        if (push_s[i] && !pop_s[i]) begin
          count_r <= count_r + 4'd1;
        end else if (pop_s[i] && !push_s[i]) begin
          count_r <= count_r - 4'd1;
        end
      end
    end

    // Payload storage needs no reset: count gates every read.
    always_ff @(posedge clock) begin
      if (push_s[i] && !flash) begin
        mem_r[wr_ptr_r] <= src_msg_s[i];
      end
    end
  end

  // Output register: load from bypass or granted head, hold while stalled.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      out_valid_r <= 1'b0;
      out_msg_r   <= '0;
    end else if (flash) begin
      out_valid_r <= 1'b0;
      out_msg_r   <= '0;
    end else if (can_load_s) begin
      if (bypass_valid_s) begin
        out_valid_r <= 1'b1;
        out_msg_r   <= src_msg_s[bypass_idx_s];
      end else if (grant_valid_s) begin
        out_valid_r <= 1'b1;
        out_msg_r   <= head_s[grant_idx_s];
      end else begin
        out_valid_r <= 1'b0;
      end
    end
  end

  // Last-granted pointer; starts at N_SRC-1 so source 0 wins first.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      rr_ptr_r <= SW'(N_SRC - 1);
    end else if (flash) begin
      rr_ptr_r <= SW'(N_SRC - 1);
    end else if (bypass_valid_s) begin
      rr_ptr_r <= bypass_idx_s;
    end else if (grant_valid_s && can_load_s) begin
      rr_ptr_r <= grant_idx_s;
    end
  end

  assign complete_info.en  = out_valid_r;
  assign complete_info.msg = out_msg_r;

endmodule

// File: tb/tb_complete_collector.sv
// Directed bench for complete_collector: scoreboard queue filled by stimulus, drained by an output monitor.
module tb_complete_collector;
  import complete_collector_pkg::*;

  logic        clock;
  logic        nreset;
  logic        flash;
  logic [11:0] occupancy;
  logic [2:0]  drv_en;
  logic [2:0]  src_rej;
  complete_info_t drv_msg [3];
  complete_info_t exp_q [$];

  int checks = 0;
  int passes = 0;

  complete_collector_if src_if [2:0] ();
  complete_collector_if out_if ();

  for (genvar g = 0; g < 3; g++) begin : g_drv
    assign src_if[g].en  = drv_en[g];
    assign src_if[g].msg = drv_msg[g];
    assign src_rej[g]    = src_if[g].reject;
  end

  complete_collector #(.N_SRC(3), .FIFO_DEPTH(4)) dut (
    .clock         (clock),
    .nreset        (nreset),
    .flash         (flash),
    .src           (src_if),
    .complete_info (out_if),
    .occupancy     (occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic complete_info_t mk(input logic [7:0] id, input logic [1:0] kind);
    complete_info_t m;
    m.commit_id = id;
    m.kind      = kind;
    m.content   = 32'hC0DE_0000 | {24'h0, id};
    return m;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    #1;
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    @(negedge clock);
    while (!out_if.en && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("wait_valid", 64'(out_if.en), 64'd1);
  endtask

  // Monitor: every transfer on the output must match the head of the scoreboard.
  always @(negedge clock) begin
    complete_info_t m;
    if (nreset && out_if.en && !out_if.reject) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_output: got commit_id %0h expected none", out_if.msg.commit_id);
      end else begin
        m = exp_q.pop_front();
        if (out_if.msg === m) passes++;
        else $display("FAIL order: got %0h expected %0h", out_if.msg, m);
      end
    end
  end

  initial begin
    logic [63:0] held;
    logic        have_held;
    int          accepts;
    nreset        = 1'b0;
    flash         = 1'b0;
    drv_en        = 3'b000;
    out_if.reject = 1'b0;
    for (int i = 0; i < 3; i++) drv_msg[i] = '0;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_en", 64'(out_if.en), 64'd0);
    check("rst_occ", 64'(occupancy), 64'd0);
    check("rst_msg", 64'(out_if.msg), 64'd0);
    check("rst_reject", 64'(src_rej), 64'd0);
    tick();
    nreset = 1'b1;
    tick();

    // Single src1 message, base latency, bit-exact payload
    drv_msg[1] = mk(8'h2A, 2'd0);
    drv_en[1]  = 1'b1;
    exp_q.push_back(mk(8'h2A, 2'd0));
    tick();
    drv_en[1] = 1'b0;
    @(negedge clock);
`ifdef COMPLETE_BYPASS_EN
    check("lat_cycle1", 64'(out_if.en), 64'd1);
`else
    check("lat_cycle1", 64'(out_if.en), 64'd0);
`endif
    tick();
    @(negedge clock);
`ifdef COMPLETE_BYPASS_EN
    check("lat_cycle2", 64'(out_if.en), 64'd0);
`else
    check("lat_cycle2", 64'(out_if.en), 64'd1);
    check("lat_msg", 64'(out_if.msg), 64'(mk(8'h2A, 2'd0)));
`endif
    wait_drain(10);

    // Flash sets pointer to 2, then three simultaneous pushes emerge src0, src1, src2
    tick();
    flash = 1'b1;
    tick();
    flash = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drv_msg[i] = mk(8'h10 + 8'(i), 2'(i));
      exp_q.push_back(mk(8'h10 + 8'(i), 2'(i)));
    end
    drv_en = 3'b111;
    tick();
    drv_en = 3'b000;
    wait_valid(10);
    for (int k = 0; k < 3; k++) begin
      check("rr_order", 64'(out_if.msg.commit_id), 64'(8'h10 + 8'(k)));
      check("rr_back2back", 64'(out_if.en), 64'd1);
      if (k < 2) @(negedge clock);
    end
    wait_drain(10);

    // Stall output while src0 pushes every cycle: 4 FIFO slots + 1 output register
    tick();
    out_if.reject = 1'b1;
    accepts   = 0;
    have_held = 1'b0;
    held      = '0;
    for (int c = 0; c < 10; c++) begin
      drv_msg[0] = mk(8'h40 + 8'(accepts), 2'd1);
      drv_en[0]  = 1'b1;
      @(negedge clock);
      if (out_if.en) begin
        if (have_held) check("stall_stable", 64'(out_if.msg), held);
        else begin
          held      = 64'(out_if.msg);
          have_held = 1'b1;
        end
      end
      if (!src_rej[0]) begin
        exp_q.push_back(mk(8'h40 + 8'(accepts), 2'd1));
        accepts++;
      end
      tick();
    end
    drv_en[0] = 1'b0;
    @(negedge clock);
    check("stall_accepts", 64'(accepts), 64'd5);
    check("stall_reject", 64'(src_rej[0]), 64'd1);
    check("stall_occ", 64'(occupancy[3:0]), 64'd4);
    tick();
    out_if.reject = 1'b0;
    wait_drain(20);

    // FIFO 2: 5..8 under stall, drain, refill 9,10 across pointer wrap
    tick();
    out_if.reject = 1'b1;
    for (int k = 5; k <= 8; k++) begin
      drv_msg[2] = mk(8'(k), 2'd2);
      drv_en[2]  = 1'b1;
      exp_q.push_back(mk(8'(k), 2'd2));
      tick();
    end
    drv_en[2] = 1'b0;
    @(negedge clock);
    check("fifo2_occ", 64'(occupancy[11:8]), 64'd3);
    tick();
    out_if.reject = 1'b0;
    wait_drain(20);
    tick();
    for (int k = 9; k <= 10; k++) begin
      drv_msg[2] = mk(8'(k), 2'd3);
      drv_en[2]  = 1'b1;
      exp_q.push_back(mk(8'(k), 2'd3));
      tick();
    end
    drv_en[2] = 1'b0;
    wait_drain(20);

    // Flash with 3 queued and output valid; stale ids must never appear
    tick();
    out_if.reject = 1'b1;
    for (int i = 0; i < 3; i++) drv_msg[i] = mk(8'h70 + 8'(i), 2'd0);
    drv_en = 3'b111;
    tick();
    drv_msg[0] = mk(8'h73, 2'd0);
    drv_en     = 3'b001;
    tick();
    drv_en = 3'b000;
    @(negedge clock);
    check("preflash_en", 64'(out_if.en), 64'd1);
    check("preflash_occ", 64'(occupancy), 64'h111);
    tick();
    flash      = 1'b1;
    drv_msg[0] = mk(8'h7F, 2'd0);
    drv_en     = 3'b001;
    tick();
    flash  = 1'b0;
    drv_en = 3'b000;
    @(negedge clock);
    check("flash_en", 64'(out_if.en), 64'd0);
    check("flash_occ", 64'(occupancy), 64'd0);
    check("flash_reject", 64'(src_rej), 64'd0);
    tick();
    out_if.reject = 1'b0;
    repeat (6) @(negedge clock);
    check("flash_quiet", 64'(out_if.en), 64'd0);

    // Async reset mid-burst, then a single push with base latency
    tick();
    for (int c = 0; c < 3; c++) begin
      drv_msg[0] = mk(8'h80 + 8'(c), 2'd1);
      drv_msg[1] = mk(8'h90 + 8'(c), 2'd2);
      exp_q.push_back(mk(8'h80 + 8'(c), 2'd1));
      exp_q.push_back(mk(8'h90 + 8'(c), 2'd2));
      drv_en = 3'b011;
      tick();
    end
    drv_en = 3'b000;
    tick();
    #2;
    nreset = 1'b0;
    #1;
    check("arst_en", 64'(out_if.en), 64'd0);
    check("arst_occ", 64'(occupancy), 64'd0);
    check("arst_msg", 64'(out_if.msg), 64'd0);
    exp_q.delete();
    tick();
    nreset = 1'b1;
    tick();
    drv_msg[2] = mk(8'h99, 2'd1);
    drv_en[2]  = 1'b1;
    exp_q.push_back(mk(8'h99, 2'd1));
    tick();
    drv_en[2] = 1'b0;
    @(negedge clock);
`ifdef COMPLETE_BYPASS_EN
    check("post_rst_lat1", 64'(out_if.en), 64'd1);
`else
    check("post_rst_lat1", 64'(out_if.en), 64'd0);
    tick();
    @(negedge clock);
    check("post_rst_lat2", 64'(out_if.en), 64'd1);
`endif
    wait_drain(10);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
